// File: rtl/halt_state_dumper_if.sv
// Output stream interface of halt_state_dumper: one dumped word per valid/ready
// handshake, tagged with its kind, source index and an end-of-dump marker.
interface halt_state_dumper_if #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_kind;
    logic [MEM_AW-1:0] out_index;
    logic              out_last;

    // Producer side: the dumper drives the word, the consumer drives ready.
    modport master (
        output out_valid, out_data, out_kind, out_index, out_last,
        input  out_ready
    );

    // Consumer side: host or logger capturing the dump.
    modport slave (
        input  out_valid, out_data, out_kind, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/halt_state_dumper.sv
// halt_state_dumper: on CPU halt, walks the register file and then data memory
// through their combinational debug read ports and streams every word out over
// a valid/ready interface. Terminal DONE state until reset.
// Optional feature macro: HALT_DUMP_CHECKSUM_EN appends one extra word holding
// the XOR of every word emitted before it.
// Assumes REG_AW <= MEM_AW: a single MEM_AW-wide counter addresses both ports.
module halt_state_dumper #(
    parameter int NUM_REGS  = 32,
    parameter int REG_AW    = 5,
    parameter int MEM_WORDS = 256,
    parameter int MEM_AW    = 8,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 halt,
    output logic [REG_AW-1:0]    reg_rd_addr,
    input  logic [DATA_W-1:0]    reg_rd_data,
    output logic [MEM_AW-1:0]    mem_rd_addr,
    input  logic [DATA_W-1:0]    mem_rd_data,
    halt_state_dumper_if.master  out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REGS,
        S_MEM,
`ifdef HALT_DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    localparam logic [MEM_AW-1:0] LAST_REG = MEM_AW'(NUM_REGS - 1);
    localparam logic [MEM_AW-1:0] LAST_MEM = MEM_AW'(MEM_WORDS - 1);

    state_t            state;
    logic [MEM_AW-1:0] index;
    logic              load;
`ifdef HALT_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    // A new word may be captured when the output register is empty or is
    // being emptied by a handshake in this same cycle.
    assign load = !out.out_valid || out.out_ready;

    // Both read ports follow the counter directly; their data is combinational.
    assign reg_rd_addr = index[REG_AW-1:0];
    assign mem_rd_addr = index;

    // DONE is only reported once the final word has actually drained, so busy
    // and done are never high together.
    assign busy = (state == S_REGS) || (state == S_MEM) ||
`ifdef HALT_DUMP_CHECKSUM_EN
                  (state == S_CSUM) ||
`endif
                  out.out_valid;
    assign done = (state == S_DONE) && !out.out_valid;

    // Dump sequencer: state, address counter and the registered output word.
    // NOTE: every register here is sequential state, so all updates use
    // non-blocking assignments; reset clears the whole output word so a
    // mid-dump reset leaves nothing half-delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            index         <= '0;
            out.out_valid <= 1'b0;
            out.out_data  <= '0;
            out.out_kind  <= 2'd0;
            out.out_index <= '0;
            out.out_last  <= 1'b0;
`ifdef HALT_DUMP_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (halt) begin
                        state <= S_REGS;
                        index <= '0;
`ifdef HALT_DUMP_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end

                S_REGS: begin
                    if (load) begin
                        out.out_valid <= 1'b1;
                        out.out_data  <= reg_rd_data;
                        out.out_kind  <= 2'd0;
                        out.out_index <= index;
                        out.out_last  <= 1'b0;
`ifdef HALT_DUMP_CHECKSUM_EN
                        csum          <= csum ^ reg_rd_data;
`endif
                        if (index == LAST_REG) begin
                            index <= '0;
                            state <= S_MEM;
                        end else begin
                            index <= index + MEM_AW'(1);
                        end
                    end
                end

                S_MEM: begin
                    if (load) begin
                        out.out_valid <= 1'b1;
                        out.out_data  <= mem_rd_data;
                        out.out_kind  <= 2'd1;
                        out.out_index <= index;
`ifdef HALT_DUMP_CHECKSUM_EN
                        csum          <= csum ^ mem_rd_data;
                        out.out_last  <= 1'b0;
                        if (index == LAST_MEM) begin
                            state <= S_CSUM;
                        end else begin
                            index <= index + MEM_AW'(1);
                        end
`else
                        out.out_last  <= (index == LAST_MEM);
                        if (index == LAST_MEM) begin
                            state <= S_DONE;
                        end else begin
                            index <= index + MEM_AW'(1);
                        end
`endif
                    end
                end

`ifdef HALT_DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (load) begin
                        out.out_valid <= 1'b1;
                        out.out_data  <= csum;
                        out.out_kind  <= 2'd2;
                        out.out_index <= '0;
                        out.out_last  <= 1'b1;
                        state         <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    // Terminal: drain the last word, then ignore halt.
                    if (out.out_valid && out.out_ready) begin
                        out.out_valid <= 1'b0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_halt_state_dumper.sv
// Self-checking bench for halt_state_dumper: table-driven full-dump runs under
// several out_ready patterns, plus hand-written reset-abort and DONE sequences.
module tb_halt_state_dumper;

    localparam int NUM_REGS  = 32;
    localparam int REG_AW    = 5;
    localparam int MEM_WORDS = 256;
    localparam int MEM_AW    = 8;
    localparam int DATA_W    = 32;
`ifdef HALT_DUMP_CHECKSUM_EN
    localparam int TOTAL = NUM_REGS + MEM_WORDS + 1;
`else
    localparam int TOTAL = NUM_REGS + MEM_WORDS;
`endif

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  index;
        logic [31:0] data;
        logic        last;
    } word_t;

    typedef struct {
        string name;
        int    ready_pct;
        bit    halt_pulse;
    } run_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              halt;
    logic [REG_AW-1:0] reg_rd_addr;
    logic [DATA_W-1:0] reg_rd_data;
    logic [MEM_AW-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] reg_file  [NUM_REGS];
    logic [DATA_W-1:0] mem_model [MEM_WORDS];

    word_t exp_tbl [$];
    run_t  runs [3];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    halt_state_dumper_if #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) dump_if ();

    halt_state_dumper #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW),
        .MEM_WORDS(MEM_WORDS),
        .MEM_AW   (MEM_AW),
        .DATA_W   (DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .halt       (halt),
        .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .out        (dump_if),
        .busy       (busy),
        .done       (done)
    );

    // Combinational regfile / data-memory debug ports.
    assign reg_rd_data = reg_file[reg_rd_addr];
    assign mem_rd_data = mem_model[mem_rd_addr];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Expected stream built from the bench's own regfile/memory contents.
    task automatic build_exp();
        logic [31:0] x;
        word_t       w;
        x = '0;
        exp_tbl.delete();
        for (int i = 0; i < NUM_REGS; i++) begin
            w = '{kind: 2'd0, index: 8'(i), data: reg_file[i], last: 1'b0};
            exp_tbl.push_back(w);
            x ^= reg_file[i];
        end
        for (int j = 0; j < MEM_WORDS; j++) begin
`ifdef HALT_DUMP_CHECKSUM_EN
            w = '{kind: 2'd1, index: 8'(j), data: mem_model[j], last: 1'b0};
`else
            w = '{kind: 2'd1, index: 8'(j), data: mem_model[j], last: (j == MEM_WORDS - 1)};
`endif
            exp_tbl.push_back(w);
            x ^= mem_model[j];
        end
`ifdef HALT_DUMP_CHECKSUM_EN
        w = '{kind: 2'd2, index: 8'd0, data: x, last: 1'b1};
        exp_tbl.push_back(w);
`endif
    endtask

    function automatic word_t cur_word();
        word_t w;
        w = '{kind: dump_if.out_kind, index: dump_if.out_index,
              data: dump_if.out_data, last: dump_if.out_last};
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        halt  = 1'b0;
        dump_if.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Starts a dump from IDLE and consumes up to stop_after words. Called at a
    // negedge; inputs change and outputs are sampled on negedges only.
    task automatic run_dump(input string tag, input int ready_pct, input bit halt_pulse,
                            input int stop_after, output int accepted);
        int    n      = 0;
        int    cycles = 0;
        bit    stall  = 1'b0;
        word_t held   = '0;
        word_t cur;
        halt = 1'b1;
        @(negedge clk);
        if (halt_pulse) halt = 1'b0;
        while (n < TOTAL && n < stop_after) begin
            cur = cur_word();
            if (stall) check({tag, " stall_hold"}, 64'(cur), 64'(held));
            dump_if.out_ready = ($urandom_range(99) < ready_pct);
            if (dump_if.out_valid && dump_if.out_ready) begin
                check($sformatf("%s word%0d", tag, n), 64'(cur), 64'(exp_tbl[n]));
                n++;
            end
            stall = dump_if.out_valid && !dump_if.out_ready;
            held  = cur;
            @(negedge clk);
            cycles++;
            if (cycles > 5000) begin
                check({tag, " timeout_words"}, 64'(n), 64'(TOTAL));
                break;
            end
        end
        accepted = n;
    endtask

    task automatic check_done(input string tag);
        check({tag, " end_valid"}, 64'(dump_if.out_valid), 64'd0);
        check({tag, " end_done"},  64'(done), 64'd1);
        check({tag, " end_busy"},  64'(busy), 64'd0);
    endtask

    initial begin
        int acc;

        runs[0] = '{name: "ready_always",      ready_pct: 100, halt_pulse: 1'b0};
        runs[1] = '{name: "ready_random",      ready_pct: 50,  halt_pulse: 1'b0};
        runs[2] = '{name: "ready_sparse_hpul", ready_pct: 25,  halt_pulse: 1'b1};

        reset = 1'b1;
        halt  = 1'b0;
        dump_if.out_ready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)  reg_file[i]  = 32'(i * 4);
        for (int j = 0; j < MEM_WORDS; j++) mem_model[j] = 32'hA500_0000 + 32'(j);
        repeat (2) @(negedge clk);

        // Reset values of the whole output word and status.
        check("rst_word",  64'(cur_word()), 64'd0);
        check("rst_valid", 64'(dump_if.out_valid), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        reset = 1'b0;

        // Idle with halt low: nothing happens.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("idle_c%0d", c), {61'd0, dump_if.out_valid, busy, done}, 64'd0);
        end

        // Full dumps under the out_ready patterns of the run table.
        build_exp();
        for (int r = 0; r < 3; r++) begin
            do_reset();
            run_dump(runs[r].name, runs[r].ready_pct, runs[r].halt_pulse, TOTAL, acc);
            check({runs[r].name, " count"}, 64'(acc), 64'(TOTAL));
            check_done(runs[r].name);
            halt = 1'b0;
        end

        // Halt re-asserted in DONE: no new output, done stays high.
        halt = 1'b1;
        dump_if.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("done_halt_c%0d", c), {62'd0, dump_if.out_valid, done}, 64'd1);
        end
        halt = 1'b0;

        // Reset after 10 accepted words aborts immediately.
        do_reset();
        run_dump("abort", 100, 1'b0, 10, acc);
        check("abort count", 64'(acc), 64'd10);
        reset = 1'b1;
        halt  = 1'b0;
        @(negedge clk);
        check("abort valid", 64'(dump_if.out_valid), 64'd0);
        check("abort busy",  64'(busy), 64'd0);
        check("abort done",  64'(done), 64'd0);
        reset = 1'b0;
        dump_if.out_ready = 1'b0;
        @(negedge clk);
        run_dump("after_abort", 70, 1'b0, TOTAL, acc);
        check("after_abort count", 64'(acc), 64'(TOTAL));
        check_done("after_abort");

`ifdef HALT_DUMP_CHECKSUM_EN
        // Checksum word: only mem[0] nonzero.
        for (int i = 0; i < NUM_REGS; i++)  reg_file[i]  = '0;
        for (int j = 0; j < MEM_WORDS; j++) mem_model[j] = '0;
        mem_model[0] = 32'h1234_5678;
        build_exp();
        do_reset();
        run_dump("csum", 60, 1'b0, TOTAL, acc);
        check("csum count", 64'(acc), 64'(TOTAL));
        check_done("csum");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/halt_state_dumper.md
Name: halt_state_dumper

Overview:
- Hardware counterpart of the bench's end-of-run dump.
- On CPU halt, walks the register file and then data memory through dedicated read ports.
- Streams every word out over a valid/ready interface for capture by a host or logger.
- Sits beside SingleCycleCPU. Uses the regfile's spare combinational read port and a data-memory debug read port.

Parameters:
NUM_REGS, 32, number of architectural registers dumped (indices 0..NUM_REGS-1)
REG_AW, 5, register address width; NUM_REGS <= 2**REG_AW
MEM_WORDS, 256, number of 32-bit data-memory words dumped (word addresses 0..MEM_WORDS-1)
MEM_AW, 8, memory word-address width; MEM_WORDS <= 2**MEM_AW
DATA_W, 32, word width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; returns block to IDLE
halt  input  1  CPU halt indication, level-sensitive
reg_rd_addr  output  REG_AW  register-file debug read address
reg_rd_data  input  DATA_W  combinational register read data for reg_rd_addr
mem_rd_addr  output  MEM_AW  data-memory debug word address
mem_rd_data  input  DATA_W  combinational memory read data for mem_rd_addr
out_valid  output  1  out_data/out_kind/out_index/out_last valid
out_ready  input  1  consumer accepts word when out_valid && out_ready
out_data  output  DATA_W  dumped word
out_kind  output  2  0=register, 1=memory, 2=checksum (feature only)
out_index  output  MEM_AW  register index or memory word address of out_data (zero-extended)
out_last  output  1  marks final word of the dump
busy  output  1  high in REGS or MEM state, or while out_valid
done  output  1  high in DONE state

Behaviour:
- Reset (sync, active-high): state=IDLE, index counter=0.
- Reset values: out_valid=0, out_data=0, out_kind=0, out_index=0, out_last=0, busy=0, done=0.
- Reset mid-dump aborts immediately. No partial-word completion.
- FSM states: IDLE, REGS, MEM, CSUM (feature only), DONE.
- IDLE -> REGS when halt=1 is sampled at a rising edge. Index is cleared to 0.
- halt is sampled only in IDLE. Deasserting halt after the dump starts has no effect.
- Read addresses: reg_rd_addr = index[REG_AW-1:0]; mem_rd_addr = index[MEM_AW-1:0]. Both are driven continuously from the counter.
- Output register loads when out_valid=0, or when out_valid && out_ready (a "load slot"). Within a load slot:
  - REGS: capture reg_rd_data, kind=0, out_index=index. If index==NUM_REGS-1: index<=0, go to MEM. Otherwise increment index.
  - MEM: capture mem_rd_data, kind=1, out_index=index. If index==MEM_WORDS-1: go to DONE (or CSUM with feature), with out_last=1 on that word. Otherwise increment index.
- Capture-to-valid latency: 1 cycle.
- Throughput: 1 word/cycle while out_ready=1. Total without feature: NUM_REGS+MEM_WORDS words.
- Backpressure: while out_valid=1 and out_ready=0, all out_* hold stable and the index does not advance.
- In DONE: out_valid clears after the final handshake, done=1. DONE is terminal until reset; halt is ignored.
- No word is dropped or duplicated under any out_ready pattern.
- The first word after start is register 0, whatever the regfile returns.

Optional Feature:
Macro: HALT_DUMP_CHECKSUM_EN
- Defined:
  - A running XOR of every emitted out_data is kept (cleared on IDLE->REGS).
  - After the last memory word the FSM enters CSUM and emits one extra word: out_kind=2, out_index=0, out_data=running XOR of all prior words, out_last=1.
  - The last memory word then has out_last=0.
  - Total words: NUM_REGS+MEM_WORDS+1.
- Not defined: no CSUM state, no XOR register. out_last is on the last memory word.

Test Plan:
- Reset, halt=0 for 20 cycles -> out_valid=0, busy=0, done=0 throughout.
- Regfile x[i]=i*4, mem[j]=0xA5000000+j, halt=1, out_ready=1 -> stream is:
  - 32 kind=0 words, 0x00000000..0x0000007C, index 0..31.
  - Then 256 kind=1 words, 0xA5000000..0xA50000FF, index 0..255.
  - out_last only on mem[255]; done=1 the cycle after the last handshake.
- Same stimulus, out_ready toggling pseudo-randomly -> identical sequence; out_* stable on every cycle with valid&&!ready.
- Dump started, reset asserted after 10 accepted words -> next cycle out_valid=0, busy=0. Re-halt gives a full stream again from register 0.
- Halt pulsed for 1 cycle then low -> full dump still completes. Halt re-asserted in DONE -> no new output.
- With HALT_DUMP_CHECKSUM_EN, regs all 0, mem[0]=0x12345678, other mem 0 -> word 289 has kind=2, data=0x12345678, out_last=1; word 288 has out_last=0.
